// File: rtl/mac_temporal_vec_pkg.sv
// mac_temporal_vec_pkg: FSM encodings, default widths and the round-half-up shift helper.
package mac_temporal_vec_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_OUT} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_MAX_LEN = 256;
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc, input logic [7:0] s);
    return (acc + (s != 8'd0 ? 64'sd1 <<< (s - 8'd1) : 64'sd0)) >>> s;
  endfunction
endpackage

// File: rtl/mac_temporal_vec_lane.sv
// mac_lane: one signed MAC lane with requantise/saturate; MAC_TEMPORAL_VEC_RELU_EN clamps negatives to 0.
module mac_lane
  import mac_temporal_vec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int SHIFT_W = $clog2(ACC_WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic add,
  input  logic cap,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_WIDTH-1:0] res,
  output logic sat
);
  localparam logic signed [63:0] MAXV = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc, acc_nx;
  logic signed [63:0] r;
  logic hi, sat_nx;
  logic [DATA_WIDTH-1:0] res_nx;
  assign prod = $signed(a) * $signed(b);
  assign acc_nx = (load ? '0 : acc) + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  // requantise the post-beat value so the result is ready on the edge entering OUT
  assign r = round_shift({{(64-ACC_WIDTH){acc_nx[ACC_WIDTH-1]}}, acc_nx}, 8'(shift));
  assign hi = r > MAXV;
`ifdef MAC_TEMPORAL_VEC_RELU_EN
  assign sat_nx = hi;
  assign res_nx = r < 64'sd0 ? '0 : hi ? MAXV[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
`else
  localparam logic signed [63:0] MINV = -(64'sd1 <<< (DATA_WIDTH - 1));
  logic lo;
  assign lo = r < MINV;
  assign sat_nx = hi || lo;
  assign res_nx = hi ? MAXV[DATA_WIDTH-1:0] : lo ? MINV[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      res <= '0;
      sat <= 1'b0;
    end else begin
      if (load || add) acc <= acc_nx;
      if (cap) begin
        res <= res_nx;
        sat <= sat_nx;
      end
    end
  end
endmodule

// File: rtl/mac_temporal_vec.sv
// mac_temporal_vec: multi-lane temporal dot-product engine with valid/ready in and out.
// Optional MAC_TEMPORAL_VEC_RELU_EN forces negative lane results to zero.
module mac_temporal_vec
  import mac_temporal_vec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int LANES = 4,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = $clog2(MAX_LEN + 1),
  parameter int SHIFT_W = $clog2(ACC_WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic abort,
  input  logic in_valid,
  output logic in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic out_valid,
  input  logic out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0] out_sat,
  output logic busy
);
  state_t state;
  logic [LEN_W-1:0] cnt, len_q, len_eff;
  logic [SHIFT_W-1:0] shift_q, shift_eff;
  logic fire, first, add, done;
  assign len_eff = cfg_len == '0 ? LEN_W'(1) : cfg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
  assign in_ready = rst_n && state != ST_OUT;
  assign fire = in_valid && in_ready && !abort;
  assign first = fire && state == ST_IDLE;
  assign add = fire && state == ST_ACCUM;
  assign done = first ? len_eff == LEN_W'(1) : add && (cnt + LEN_W'(1)) == len_q;
  // the first beat requantises with the live shift since shift_q is only latched on that edge
  assign shift_eff = state == ST_IDLE ? cfg_shift : shift_q;
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      len_q <= '0;
      shift_q <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (first) begin
          len_q <= len_eff;
          shift_q <= cfg_shift;
          cnt <= LEN_W'(1);
          state <= done ? ST_OUT : ST_ACCUM;
          out_valid <= done;
        end
        ST_ACCUM: if (abort) begin
          state <= ST_IDLE;
          cnt <= '0;
        end else if (add) begin
          cnt <= cnt + LEN_W'(1);
          if (done) begin
            state <= ST_OUT;
            out_valid <= 1'b1;
          end
        end
        ST_OUT: if (out_ready) begin
          state <= ST_IDLE;
          out_valid <= 1'b0;
          cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SHIFT_W(SHIFT_W)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .load(first),
      .add(add),
      .cap(done),
      .a(in_a[g*DATA_WIDTH +: DATA_WIDTH]),
      .b(in_b[g*DATA_WIDTH +: DATA_WIDTH]),
      .shift(shift_eff),
      .res(out_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .sat(out_sat[g])
    );
  end
endmodule

// File: tb/tb_mac_temporal_vec.sv
// tb_mac_temporal_vec: randomized + directed scoreboard bench against an arithmetic reference model.
module tb_mac_temporal_vec;
  localparam int DW = 8, AW = 32, LN = 4, ML = 256, LW = 9, SW = 5;
  typedef struct {logic [LN*DW-1:0] d; logic [LN-1:0] s;} res_t;
  typedef struct {logic [LN*DW-1:0] a; logic [LN*DW-1:0] b;} beat_t;
  logic clk = 0, rst_n = 0, abort = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] cfg_len = '0;
  logic [SW-1:0] cfg_shift = '0;
  logic [LN*DW-1:0] in_a = '0, in_b = '0, out_data;
  logic [LN-1:0] out_sat;
  logic in_ready, out_valid, busy;
  int checks = 0, fails = 0;
  bit hold = 0;
  res_t exp_q[$];
  beat_t dir_q[$];

  mac_temporal_vec dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_shift(cfg_shift), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic res_t model(input longint sum[LN], input int sh);
    res_t r;
    longint v;
    longint mx = (longint'(1) <<< (DW - 1)) - 1;
    longint mn = -(longint'(1) <<< (DW - 1));
    for (int i = 0; i < LN; i++) begin
      v = sh > 0 ? (sum[i] + (longint'(1) <<< (sh - 1))) >>> sh : sum[i];
      r.s[i] = 1'b0;
      if (v > mx) begin v = mx; r.s[i] = 1'b1; end
      if (v < mn) begin
`ifdef MAC_TEMPORAL_VEC_RELU_EN
        v = 0;
`else
        v = mn; r.s[i] = 1'b1;
`endif
      end
`ifdef MAC_TEMPORAL_VEC_RELU_EN
      if (v < 0) v = 0;
`endif
      r.d[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic beat_t dir_beat(input int a0, input int b0, input int a1, input int b1);
    beat_t x;
    x.a = {$urandom, $urandom};
    x.b = {$urandom, $urandom};
    x.a[DW-1:0] = DW'(a0); x.b[DW-1:0] = DW'(b0);
    x.a[2*DW-1:DW] = DW'(a1); x.b[2*DW-1:DW] = DW'(b1);
    return x;
  endfunction

  // mode: 0 normal, 1 abort after n_send beats, 2 reset after n_send beats
  task automatic issue(input int len_cfg, input int sh, input int n_send, input int mode, input bit gaps);
    longint sum[LN];
    int n = mode == 0 ? (len_cfg == 0 ? 1 : len_cfg > ML ? ML : len_cfg) : n_send;
    beat_t bt;
    logic signed [DW-1:0] xa, xb;
    int w;
    foreach (sum[i]) sum[i] = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); in_valid = 0; end
      @(negedge clk);
      if (dir_q.size() > 0) bt = dir_q.pop_front();
      else begin bt.a = {$urandom, $urandom}; bt.b = {$urandom, $urandom}; end
      in_valid = 1; in_a = bt.a; in_b = bt.b;
      cfg_len = k == 0 ? LW'(len_cfg) : LW'($urandom);
      cfg_shift = k == 0 ? SW'(sh) : SW'($urandom);
      w = 0;
      while (!in_ready && w < 300) begin @(negedge clk); w++; end
      if (w >= 300) chk("in_ready_timeout", 0, 1);
      for (int i = 0; i < LN; i++) begin
        xa = bt.a[i*DW +: DW]; xb = bt.b[i*DW +: DW];
        sum[i] += longint'(xa) * longint'(xb);
      end
    end
    if (mode == 0) exp_q.push_back(model(sum, sh));
    @(negedge clk);
    in_valid = 0;
    if (mode == 0) chk("latency_out_valid", out_valid, 1);
    else if (mode == 1) begin
      abort = 1; in_valid = 1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      @(negedge clk);
      abort = 0; in_valid = 0;
      chk("abort_idle_busy", busy, 0);
      chk("abort_no_out", out_valid, 0);
    end else begin
      rst_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1;
    end
  endtask

  // monitor: drives out_ready, pops expectations on consumption, checks hold stability
  initial begin
    res_t e;
    logic [LN*DW-1:0] pd;
    logic [LN-1:0] ps;
    bit waiting = 0;
    forever begin
      @(negedge clk);
      if (waiting && out_valid) begin
        chk("hold_data_stable", out_data, pd);
        chk("hold_sat_stable", out_sat, ps);
      end
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      waiting = out_valid && !out_ready;
      pd = out_data; ps = out_sat;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sat", out_sat, e.s);
        end
      end
    end
  end

  initial begin
    int w;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_sat", out_sat, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    // lane0 sum 20
    dir_q.push_back(dir_beat(2, 3, 0, 0));
    dir_q.push_back(dir_beat(4, 5, 0, 0));
    dir_q.push_back(dir_beat(-1, 6, 0, 0));
    issue(3, 0, 0, 0, 0);
    // positive clamp / relu negative
    dir_q.push_back(dir_beat(-128, -128, -128, 127));
    issue(1, 0, 0, 0, 0);
    // round-half-up: 7>>1 -> 4, -7>>1 -> -3
    dir_q.push_back(dir_beat(3, 1, -3, 1));
    dir_q.push_back(dir_beat(4, 1, -4, 1));
    issue(2, 1, 0, 0, 0);
    // backpressure: result held, beats refused
    hold = 1;
    issue(2, 3, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(negedge clk);
    in_valid = 0; hold = 0;
    // abort then clean vector of 1+1
    issue(4, 0, 2, 1, 0);
    dir_q.push_back(dir_beat(1, 1, 1, 1));
    dir_q.push_back(dir_beat(1, 1, 1, 1));
    issue(2, 0, 0, 0, 0);
    issue(0, 2, 0, 0, 0);
    issue(4, 0, 2, 2, 0);
    issue(3, 0, 0, 0, 1);
    issue(300, 10, 0, 0, 1);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) issue($urandom_range(2, 8), $urandom_range(0, 31), $urandom_range(1, 1), 1, 1);
      else issue($urandom_range(0, 12), $urandom_range(0, 31), 0, 0, 1);
    end
    w = 0;
    while (exp_q.size() > 0 && w < 2000) begin @(negedge clk); w++; end
    chk("drain_scoreboard", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
